// File: rtl/pistorm_pkg.sv
// Shared PiStorm CPLD definitions: arbiter state codes, register map
// addresses and STATUS bit positions used by the Pi status path.
package pistorm_pkg;

  localparam logic [2:0] ARB_IDLE    = 3'd0;
  localparam logic [2:0] ARB_DRAIN   = 3'd1;
  localparam logic [2:0] ARB_GRANT   = 3'd2;
  localparam logic [2:0] ARB_OWNED   = 3'd3;
  localparam logic [2:0] ARB_RECOVER = 3'd4;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_ADDR_LO = 3'd1;
  localparam logic [2:0] REG_ADDR_HI = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  localparam int STATUS_EXT_OWNS_BIT = 14;
  localparam int STATUS_STALL_BIT    = 13;

  // Every state except IDLE keeps the cycle engine from launching a new cycle.
  function automatic logic arbHolds(input logic [2:0] state);
    return (state != ARB_IDLE);
  endfunction

endpackage

// File: rtl/c7m_edge_sync.sv
// Three-flop synchronizer for the 7 MHz M68K_CLK, producing one-PI_CLK
// rise/fall pulses. Shared by the arbiter, cycle engine and IPL sampler.
module c7m_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_m68kClk,
  output logic o_c7mRise,
  output logic o_c7mFall
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_m68kClk};
    end
  end

  assign o_c7mFall = r_sync[2] & ~r_sync[1];
  assign o_c7mRise = ~r_sync[2] & r_sync[1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// CPU side of the 68000 BR/BG/BGACK handshake: lets Amiga DMA masters take
// the bus from the Pi-driven cycle engine, and reports ownership/statistics.
module m68k_bus_arbiter
  import pistorm_pkg::*;
#(
  parameter int BR_FILTER   = 2,
  parameter int STALL_LIMIT = 1024
) (
  input  logic        PI_CLK,
  input  logic        RST,
  input  logic        M68K_CLK,
  input  logic        M68K_BR_n,
  input  logic        M68K_BGACK_n,
  input  logic        M68K_AS_n,
  input  logic        ENG_IDLE,
  input  logic        ARB_ENABLE,
  input  logic        STALL_CLR,
  output logic        M68K_BG_n,
  output logic        ENG_HOLD,
  output logic        EXT_OWNS_BUS,
  output logic [15:0] GRANT_COUNT,
  output logic        STALL_FLAG
);

  localparam int BRW = $clog2(BR_FILTER + 2);
  localparam int SCW = $clog2(STALL_LIMIT + 2);
  localparam logic [BRW-1:0] BR_SAT    = BRW'(BR_FILTER);
  localparam logic [SCW-1:0] STALL_SAT = SCW'(STALL_LIMIT);
  localparam logic [SCW-1:0] STALL_PRE = SCW'(STALL_LIMIT - 1);

  logic [1:0]     r_brSync;
  logic [1:0]     r_bgackSync;
  logic [2:0]     r_state;
  logic [2:0]     w_stateNext;
  logic [BRW-1:0] r_brCnt;
  logic [BRW-1:0] w_brCntNext;
  logic [SCW-1:0] r_stallCnt;
  logic [15:0]    r_grantCount;
  logic           r_stallFlag;
  logic           r_bgN;
  logic           r_hold;
  logic           r_extOwns;
  logic           w_c7mFall;
  logic           w_unusedC7mRise;
  logic           w_brN;
  logic           w_bgackN;
  logic           w_brValid;
  logic           w_stallSet;
  logic           w_tenureDone;

  c7m_edge_sync u_c7mSync (
    .i_clk     (PI_CLK),
    .i_rst     (RST),
    .i_m68kClk (M68K_CLK),
    .o_c7mRise (w_unusedC7mRise),
    .o_c7mFall (w_c7mFall)
  );

  always_ff @(posedge PI_CLK) begin
    if (RST) begin
      r_brSync    <= 2'b11;
      r_bgackSync <= 2'b11;
    end else begin
      r_brSync    <= {r_brSync[0], M68K_BR_n};
      r_bgackSync <= {r_bgackSync[0], M68K_BGACK_n};
    end
  end

  assign w_brN    = r_brSync[1];
  assign w_bgackN = r_bgackSync[1];

  // Validity looks at the post-increment count so the request qualifies on
  // the BR_FILTER-th falling edge itself rather than one edge later.
  always_comb begin
    w_brCntNext = r_brCnt;
    if (w_brN) begin
      w_brCntNext = '0;
    end else if (r_brCnt != BR_SAT) begin
      w_brCntNext = r_brCnt + 1'b1;
    end
  end

  assign w_brValid = (w_brCntNext >= BR_SAT);

  always_comb begin
    w_stateNext = r_state;
    if (w_c7mFall) begin
      case (r_state)
        ARB_IDLE:    if (ARB_ENABLE && w_brValid) w_stateNext = ARB_DRAIN;
        ARB_DRAIN: begin
          if (w_brN) w_stateNext = ARB_IDLE;
          else if (ENG_IDLE && M68K_AS_n) w_stateNext = ARB_GRANT;
        end
        ARB_GRANT: begin
          if (!w_bgackN && M68K_AS_n) w_stateNext = ARB_OWNED;
          else if (w_brN && w_bgackN) w_stateNext = ARB_IDLE;
        end
        ARB_OWNED:   if (w_bgackN) w_stateNext = ARB_RECOVER;
        ARB_RECOVER: w_stateNext = w_brValid ? ARB_DRAIN : ARB_IDLE;
        default:     w_stateNext = ARB_IDLE;
      endcase
    end
  end

  assign w_tenureDone = (r_state == ARB_OWNED) && (w_stateNext == ARB_RECOVER);

  always_ff @(posedge PI_CLK) begin
    if (RST) begin
      r_state      <= ARB_IDLE;
      r_brCnt      <= '0;
      r_bgN        <= 1'b1;
      r_hold       <= 1'b0;
      r_extOwns    <= 1'b0;
      r_grantCount <= 16'd0;
    end else begin
      if (w_c7mFall) r_brCnt <= w_brCntNext;
      r_state   <= w_stateNext;
      r_bgN     <= (w_stateNext != ARB_GRANT);
      r_hold    <= arbHolds(w_stateNext);
      r_extOwns <= (w_stateNext == ARB_OWNED);
      if (w_tenureDone) r_grantCount <= r_grantCount + 16'd1;
    end
  end

  // A set on the same PI_CLK as a STALL_CLR pulse must not be lost.
  assign w_stallSet = r_hold && w_c7mFall && (r_stallCnt == STALL_PRE);

  always_ff @(posedge PI_CLK) begin
    if (RST) begin
      r_stallCnt  <= '0;
      r_stallFlag <= 1'b0;
    end else begin
      if (!r_hold) begin
        r_stallCnt <= '0;
      end else if (w_c7mFall && (r_stallCnt != STALL_SAT)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      if (w_stallSet) begin
        r_stallFlag <= 1'b1;
      end else if (STALL_CLR) begin
        r_stallFlag <= 1'b0;
      end
    end
  end

  assign M68K_BG_n    = r_bgN;
  assign ENG_HOLD     = r_hold;
  assign EXT_OWNS_BUS = r_extOwns;
  assign GRANT_COUNT  = r_grantCount;
  assign STALL_FLAG   = r_stallFlag;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: a vector table for the basic
// handshake plus hand-written sequences for stall, reset and wrap cases.
module tb_m68k_bus_arbiter;

  logic        PI_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        M68K_CLK = 1'b0;
  logic        M68K_BR_n = 1'b1;
  logic        M68K_BGACK_n = 1'b1;
  logic        M68K_AS_n = 1'b1;
  logic        ENG_IDLE = 1'b1;
  logic        ARB_ENABLE = 1'b1;
  logic        STALL_CLR = 1'b0;
  logic        M68K_BG_n;
  logic        ENG_HOLD;
  logic        EXT_OWNS_BUS;
  logic [15:0] GRANT_COUNT;
  logic        STALL_FLAG;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    logic        br;
    logic        bgack;
    logic        en;
    logic        expBgN;
    logic        expHold;
    logic        expExt;
    logic [15:0] expCount;
  } vec_t;

  vec_t vecs[$];

  m68k_bus_arbiter #(.BR_FILTER(2), .STALL_LIMIT(8)) dut (
    .PI_CLK       (PI_CLK),
    .RST          (RST),
    .M68K_CLK     (M68K_CLK),
    .M68K_BR_n    (M68K_BR_n),
    .M68K_BGACK_n (M68K_BGACK_n),
    .M68K_AS_n    (M68K_AS_n),
    .ENG_IDLE     (ENG_IDLE),
    .ARB_ENABLE   (ARB_ENABLE),
    .STALL_CLR    (STALL_CLR),
    .M68K_BG_n    (M68K_BG_n),
    .ENG_HOLD     (ENG_HOLD),
    .EXT_OWNS_BUS (EXT_OWNS_BUS),
    .GRANT_COUNT  (GRANT_COUNT),
    .STALL_FLAG   (STALL_FLAG)
  );

  always #5 PI_CLK = ~PI_CLK;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Grant must never be visible while the address strobe is asserted.
  always @(negedge PI_CLK) begin
    if (!RST && !M68K_AS_n) checkOutput("bg_while_as", 16'(M68K_BG_n), 16'd1);
  end

  // One 7 MHz cycle: 4 PI_CLK high, 4 low. STALL_CLR can be pulsed on the
  // PI_CLK edge at which the falling edge is acted upon.
  task automatic runBusCycle(input logic pulseClr);
    M68K_CLK = 1'b1;
    repeat (4) @(negedge PI_CLK);
    M68K_CLK = 1'b0;
    repeat (2) @(negedge PI_CLK);
    STALL_CLR = pulseClr;
    @(negedge PI_CLK);
    STALL_CLR = 1'b0;
    @(negedge PI_CLK);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) runBusCycle(1'b0);
  endtask

  task automatic doReset();
    @(negedge PI_CLK);
    RST = 1'b1;
    M68K_BR_n = 1'b1;
    M68K_BGACK_n = 1'b1;
    M68K_AS_n = 1'b1;
    ENG_IDLE = 1'b1;
    ARB_ENABLE = 1'b1;
    STALL_CLR = 1'b0;
    repeat (3) @(negedge PI_CLK);
    RST = 1'b0;
  endtask

  task automatic addVec(input logic br, input logic bgack, input logic en, input logic bgN,
                        input logic hold, input logic ext, input logic [15:0] cnt);
    vec_t v;
    v.br = br; v.bgack = bgack; v.en = en;
    v.expBgN = bgN; v.expHold = hold; v.expExt = ext; v.expCount = cnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    M68K_BR_n = v.br;
    M68K_BGACK_n = v.bgack;
    ARB_ENABLE = v.en;
    runBusCycle(1'b0);
  endtask

  task automatic checkBus(input string tag, input logic bgN, input logic hold, input logic ext);
    checkOutput({tag, "_bg"}, 16'(M68K_BG_n), 16'(bgN));
    checkOutput({tag, "_hold"}, 16'(ENG_HOLD), 16'(hold));
    checkOutput({tag, "_ext"}, 16'(EXT_OWNS_BUS), 16'(ext));
  endtask

  initial begin
    // single request with a 10-cycle tenure
    addVec(0, 1, 1, 1, 0, 0, 0);
    addVec(0, 1, 1, 1, 1, 0, 0);
    addVec(0, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) addVec(1, 0, 1, 1, 1, 1, 0);
    addVec(1, 1, 1, 1, 1, 0, 1);
    addVec(1, 1, 1, 1, 0, 0, 1);
    // one-edge glitch
    addVec(0, 1, 1, 1, 0, 0, 1);
    addVec(1, 1, 1, 1, 0, 0, 1);
    addVec(1, 1, 1, 1, 0, 0, 1);
    // spurious request released in GRANT
    addVec(0, 1, 1, 1, 0, 0, 1);
    addVec(0, 1, 1, 1, 1, 0, 1);
    addVec(0, 1, 1, 0, 1, 0, 1);
    addVec(1, 1, 1, 1, 0, 0, 1);
    addVec(1, 1, 1, 1, 0, 0, 1);
    // enable gating in IDLE, ignored once the tenure has started
    for (int i = 0; i < 3; i++) addVec(0, 1, 0, 1, 0, 0, 1);
    addVec(0, 1, 1, 1, 1, 0, 1);
    addVec(0, 1, 0, 0, 1, 0, 1);
    addVec(1, 0, 0, 1, 1, 1, 1);
    addVec(1, 1, 0, 1, 1, 0, 2);
    addVec(1, 1, 0, 1, 0, 0, 2);

    doReset();
    checkBus("reset", 1'b1, 1'b0, 1'b0);
    checkOutput("reset_count", GRANT_COUNT, 16'd0);
    checkOutput("reset_stall", 16'(STALL_FLAG), 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkBus($sformatf("vec%0d", i), vecs[i].expBgN, vecs[i].expHold, vecs[i].expExt);
      checkOutput($sformatf("vec%0d_count", i), GRANT_COUNT, vecs[i].expCount);
    end

    // mid-cycle request: engine busy with AS asserted
    doReset();
    M68K_AS_n = 1'b0;
    ENG_IDLE = 1'b0;
    M68K_BR_n = 1'b0;
    runCycles(2);
    checkBus("mid_drain", 1'b1, 1'b1, 1'b0);
    runCycles(3);
    checkBus("mid_wait", 1'b1, 1'b1, 1'b0);
    M68K_AS_n = 1'b1;
    ENG_IDLE = 1'b1;
    runCycles(1);
    checkBus("mid_grant", 1'b0, 1'b1, 1'b0);

    // stall: flag sets on the 8th hold edge, is sticky, and set beats clear
    doReset();
    M68K_BR_n = 1'b0;
    runCycles(3);
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    runCycles(6);
    checkOutput("stall_before", 16'(STALL_FLAG), 16'd0);
    runCycles(1);
    checkOutput("stall_set", 16'(STALL_FLAG), 16'd1);
    runCycles(12);
    checkOutput("stall_held", 16'(STALL_FLAG), 16'd1);
    checkBus("stall_owned", 1'b1, 1'b1, 1'b1);
    M68K_BGACK_n = 1'b1;
    runCycles(2);
    checkOutput("stall_sticky", 16'(STALL_FLAG), 16'd1);
    checkOutput("stall_count", GRANT_COUNT, 16'd1);
    @(negedge PI_CLK);
    STALL_CLR = 1'b1;
    @(negedge PI_CLK);
    STALL_CLR = 1'b0;
    checkOutput("stall_clr", 16'(STALL_FLAG), 16'd0);
    M68K_BR_n = 1'b0;
    runCycles(3);
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    runCycles(6);
    checkOutput("stall2_before", 16'(STALL_FLAG), 16'd0);
    runBusCycle(1'b1);
    checkOutput("stall_set_wins", 16'(STALL_FLAG), 16'd1);
    M68K_BGACK_n = 1'b1;
    runCycles(2);

    // reset while an external master owns the bus
    doReset();
    M68K_BR_n = 1'b0;
    runCycles(3);
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    runCycles(1);
    M68K_BGACK_n = 1'b1;
    runCycles(2);
    checkOutput("pre_rst_count", GRANT_COUNT, 16'd1);
    M68K_BR_n = 1'b0;
    runCycles(3);
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    runCycles(1);
    checkBus("pre_rst_owned", 1'b1, 1'b1, 1'b1);
    @(negedge PI_CLK);
    RST = 1'b1;
    @(posedge PI_CLK);
    #1;
    checkBus("rst_owned", 1'b1, 1'b0, 1'b0);
    checkOutput("rst_owned_count", GRANT_COUNT, 16'd0);
    checkOutput("rst_owned_stall", 16'(STALL_FLAG), 16'd0);
    @(negedge PI_CLK);
    RST = 1'b0;
    M68K_BGACK_n = 1'b1;

    // counter wrap, then back-to-back tenure through RECOVER -> DRAIN
    doReset();
    @(negedge PI_CLK);
    force dut.r_grantCount = 16'hFFFF;
    @(negedge PI_CLK);
    release dut.r_grantCount;
    M68K_BR_n = 1'b0;
    runCycles(3);
    M68K_BGACK_n = 1'b0;
    runCycles(1);
    checkOutput("wrap_pre", GRANT_COUNT, 16'hFFFF);
    M68K_BGACK_n = 1'b1;
    runCycles(1);
    checkOutput("wrap_count", GRANT_COUNT, 16'h0000);
    checkBus("wrap_recover", 1'b1, 1'b1, 1'b0);
    runCycles(1);
    checkBus("b2b_drain", 1'b1, 1'b1, 1'b0);
    runCycles(1);
    checkBus("b2b_grant", 1'b0, 1'b1, 1'b0);
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    runCycles(1);
    M68K_BGACK_n = 1'b1;
    runCycles(2);
    checkOutput("b2b_count", GRANT_COUNT, 16'h0001);
    checkBus("b2b_idle", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
